// File: rtl/inc_count_reg.sv
// inc_count_reg: registered up-counter built around an N-bit ripple half-adder
// incrementer, with clear, load, wrap/saturate handling, a sticky overflow flag
// and a valid/ready snapshot port.
//
// Ports
//   clk         in   1  clock, all state changes on the rising edge
//   rst         in   1  synchronous active-high reset
//   en          in   1  count enable, drives the incrementer carry-in
//   clr         in   1  synchronous clear of count and ovf
//   load        in   1  load count from load_val
//   load_val    in   N  value used by load
//   count       out  N  registered counter value
//   tc          out  1  terminal count (count == all-ones)
//   ovf         out  1  sticky overflow flag
//   snap_req    in   1  request a snapshot of count
//   snap_valid  out  1  snap_data holds a valid snapshot
//   snap_ready  in   1  consumer accepts the snapshot
//   snap_data   out  N  captured count value
module inc_count_reg #(
    parameter int unsigned N    = 8,
    parameter bit          WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         ovf,
    input  logic         snap_req,
    output logic         snap_valid,
    input  logic         snap_ready,
    output logic [N-1:0] snap_data
);

    typedef enum logic [0:0] {StEmpty, StFull} snap_st_e;

    logic [N-1:0] sum;
    logic [N-1:0] carry;
    snap_st_e     snap_st;

    // Ripple half-adder incrementer: carry-in is en, no carry-out is kept.
    assign carry[0] = en;
    for (genvar i = 0; i < N; i++) begin : g_rcha
        assign sum[i] = count[i] ^ carry[i];
        if (i < N - 1) begin : g_carry
            assign carry[i+1] = count[i] & carry[i];
        end
    end

    assign tc = &count;

    // Counter: rst > clr > load > en.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (tc) begin
                // Overflow comes from tc since the incrementer drops its carry-out.
                ovf   <= 1'b1;
                count <= WRAP ? '0 : count;
            end else begin
                count <= sum;
            end
        end
    end

    // Snapshot FSM; captures the pre-update count and ignores clr/load.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_st    <= StEmpty;
            snap_valid <= 1'b0;
            snap_data  <= '0;
        end else begin
            unique case (snap_st)
                StEmpty: begin
                    if (snap_req) begin
                        snap_data  <= count;
                        snap_st    <= StFull;
                        snap_valid <= 1'b1;
                    end
                end
                StFull: begin
                    // While not accepted, new requests are dropped, not queued.
                    if (snap_ready) begin
                        if (snap_req) begin
                            snap_data <= count;
                        end else begin
                            snap_st    <= StEmpty;
                            snap_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    snap_st    <= StEmpty;
                    snap_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inc_count_reg.sv
// Testbench for inc_count_reg: one wrapping and one saturating instance share
// all inputs; a reference model pushes expected state into a scoreboard queue
// each cycle, and the entry is popped and compared after the clock edge.
module tb_inc_count_reg;

    logic       clk = 1'b0;
    logic       rst, en, clr, load, snap_req, snap_ready;
    logic [7:0] load_val;

    logic [7:0] cnt_w, cnt_s, sd_w, sd_s;
    logic       tc_w, tc_s, ovf_w, ovf_s, sv_w, sv_s;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] cnt_w;
        logic       ovf_w;
        logic       sv_w;
        logic [7:0] sd_w;
        logic [7:0] cnt_s;
        logic       ovf_s;
        logic       sv_s;
        logic [7:0] sd_s;
    } exp_t;

    exp_t sb[$];

    // Reference model state, index 0 = wrapping, 1 = saturating.
    logic [7:0] m_cnt [2];
    logic       m_ovf [2];
    logic       m_sv  [2];
    logic [7:0] m_sd  [2];

    always #5 clk = ~clk;

    inc_count_reg #(.N(8), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_w), .tc(tc_w), .ovf(ovf_w), .snap_req(snap_req), .snap_valid(sv_w),
        .snap_ready(snap_ready), .snap_data(sd_w)
    );

    inc_count_reg #(.N(8), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_s), .tc(tc_s), .ovf(ovf_s), .snap_req(snap_req), .snap_valid(sv_s),
        .snap_ready(snap_ready), .snap_data(sd_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model using the inputs currently driven.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] c;
            c = m_cnt[k];
            if (rst) begin
                m_sv[k] = 1'b0;
                m_sd[k] = 8'h00;
            end else if (!m_sv[k]) begin
                if (snap_req) begin
                    m_sv[k] = 1'b1;
                    m_sd[k] = c;
                end
            end else if (snap_ready) begin
                if (snap_req) m_sd[k] = c;
                else          m_sv[k] = 1'b0;
            end
            if (rst || clr) begin
                m_cnt[k] = 8'h00;
                m_ovf[k] = 1'b0;
            end else if (load) begin
                m_cnt[k] = load_val;
            end else if (en) begin
                if (c == 8'hFF) begin
                    m_ovf[k] = 1'b1;
                    m_cnt[k] = (k == 0) ? 8'h00 : 8'hFF;
                end else begin
                    m_cnt[k] = 8'((int'(c) + 1) % 256);
                end
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        e = '{m_cnt[0], m_ovf[0], m_sv[0], m_sd[0], m_cnt[1], m_ovf[1], m_sv[1], m_sd[1]};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("cnt_w", 32'(cnt_w), 32'(e.cnt_w));
        chk("ovf_w", 32'(ovf_w), 32'(e.ovf_w));
        chk("tc_w", 32'(tc_w), 32'(e.cnt_w == 8'hFF));
        chk("sv_w", 32'(sv_w), 32'(e.sv_w));
        if (e.sv_w) chk("sd_w", 32'(sd_w), 32'(e.sd_w));
        chk("cnt_s", 32'(cnt_s), 32'(e.cnt_s));
        chk("ovf_s", 32'(ovf_s), 32'(e.ovf_s));
        chk("tc_s", 32'(tc_s), 32'(e.cnt_s == 8'hFF));
        chk("sv_s", 32'(sv_s), 32'(e.sv_s));
        if (e.sv_s) chk("sd_s", 32'(sd_s), 32'(e.sd_s));
    endtask

    task automatic idle();
        rst = 0; en = 0; clr = 0; load = 0; snap_req = 0; snap_ready = 0; load_val = 8'h00;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 8'h00; m_ovf[k] = 1'b0; m_sv[k] = 1'b0; m_sd[k] = 8'h00;
        end
        idle();

        // Reset held 2 cycles with en and snap_req active.
        rst = 1; en = 1; snap_req = 1;
        cycle(); cycle();
        idle();
        chk("rst_count", 32'(cnt_w), 32'h0);
        chk("rst_ovf", 32'(ovf_w), 32'h0);
        chk("rst_valid", 32'(sv_w), 32'h0);
        chk("rst_data", 32'(sd_w), 32'h0);

        // Count 1..5, then hold.
        en = 1;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            chk("count_step", 32'(cnt_w), 32'(i));
        end
        en = 0;
        cycle(); cycle();
        chk("count_hold", 32'(cnt_w), 32'h5);

        // Snapshot at count 3.
        clr = 1; cycle(); clr = 0;
        en = 1; cycle(); cycle(); cycle();
        snap_req = 1; cycle();
        chk("snap_data", 32'(sd_w), 32'h3);
        chk("snap_valid", 32'(sv_w), 32'h1);
        chk("snap_count_moved", 32'(cnt_w), 32'h4);
        en = 0; snap_ready = 0;
        for (int i = 0; i < 4; i++) cycle();
        chk("snap_held", 32'(sd_w), 32'h3);
        snap_ready = 1; en = 1; cycle();
        chk("snap_recap", 32'(sd_w), 32'h4);
        chk("snap_recap_valid", 32'(sv_w), 32'h1);
        snap_req = 0; snap_ready = 0; en = 0;
        clr = 1; cycle(); clr = 0;
        chk("snap_survives_clr", 32'(sv_w), 32'h1);
        rst = 1; cycle(); rst = 0;
        chk("snap_rst_drop", 32'(sv_w), 32'h0);

        // Wrap versus saturate from FE.
        load = 1; load_val = 8'hFE; cycle(); load = 0;
        en = 1;
        cycle();
        chk("wrap_ff", 32'(cnt_w), 32'hFF);
        chk("wrap_tc", 32'(tc_w), 32'h1);
        cycle();
        chk("wrap_00", 32'(cnt_w), 32'h00);
        chk("wrap_ovf", 32'(ovf_w), 32'h1);
        chk("sat_ff", 32'(cnt_s), 32'hFF);
        cycle();
        chk("wrap_01", 32'(cnt_w), 32'h01);
        en = 0; clr = 1; cycle(); clr = 0;
        chk("clr_count", 32'(cnt_w), 32'h0);
        chk("clr_ovf", 32'(ovf_w), 32'h0);

        // Saturate from FF.
        load = 1; load_val = 8'hFF; cycle(); load = 0;
        en = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("sat_hold", 32'(cnt_s), 32'hFF);
            chk("sat_ovf", 32'(ovf_s), 32'h1);
        end
        en = 0;

        // Priority.
        load = 1; load_val = 8'h10; cycle();
        clr = 1; en = 1; cycle(); clr = 0;
        chk("prio_clr", 32'(cnt_w), 32'h0);
        load_val = 8'hFF; en = 0; cycle();
        en = 1; cycle();
        chk("prio_load_cnt", 32'(cnt_w), 32'hFF);
        chk("prio_load_ovf", 32'(ovf_w), 32'h0);
        load = 0; cycle();
        load = 1; cycle(); load = 0; en = 0;
        chk("prio_ovf_kept", 32'(ovf_s), 32'h1);

        // Mixed random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            rst = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 14) == 0);
            load = ($urandom_range(0, 7) == 0);
            load_val = 8'($urandom_range(0, 255));
            en = ($urandom_range(0, 3) != 0);
            snap_req = $urandom_range(0, 1) == 1;
            snap_ready = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
